// File: rtl/ysyx_22051013_if_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_if_fetch
//
// Instruction-fetch stage. Owns the architectural fetch PC, issues one
// instruction-memory request at a time, and presents each fetched word
// with its PC to the IF/ID pipeline register. The next PC comes from an
// EX redirect (highest priority), the branch predictor, or PC+4. Fetches
// made stale by a redirect are discarded when their response returns.
//
// Optional feature macro: YSYX_22051013_FETCH_ALIGN_CHK_EN
//   defined   : a misaligned fetch PC issues no request and produces a
//               fetch_misalign output slot instead.
//   undefined : pc[1:0] is ignored and fetch_misalign is tied to 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   ifid_stall           IF/ID holding; current output not consumed
//   redirect_valid/pc    EX-stage redirect request and target
//   bpu_jump/target      predictor decision for the delivered instruction
//   imem_req_*           request channel (valid/ready, word address)
//   imem_rsp_*           response channel (valid, 32-bit instruction)
//   if_valid/inst/pc     registered output to IF/ID
//   fetch_misalign       misaligned-PC flag on the output slot
// ---------------------------------------------------------------------------
module ysyx_22051013_if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifid_stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        bpu_jump,
  input  logic [63:0] bpu_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [63:0] r_pc;
  logic [63:0] w_pcNext;
  logic        r_drop;
  logic        w_dropNext;
  logic        r_ifValid;
  logic        w_ifValidNext;
  logic [31:0] r_ifInst;
  logic [31:0] w_ifInstNext;
  logic [63:0] r_ifPc;
  logic [63:0] w_ifPcNext;
  logic        w_misalignNext;
`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
  logic        r_misalign;
`endif

  // A request is only offered from REQ and is suppressed by a redirect in
  // the same cycle, so the old PC is never sent once EX has overridden it.
`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
  assign imem_req_valid = (r_state == S_REQ) && !redirect_valid && (r_pc[1:0] == 2'b00);
  assign fetch_misalign = r_misalign;
`else
  assign imem_req_valid = (r_state == S_REQ) && !redirect_valid;
  assign fetch_misalign = 1'b0;
`endif
  assign imem_req_addr = {r_pc[63:2], 2'b00};
  assign if_valid      = r_ifValid;
  assign if_inst       = r_ifInst;
  assign if_pc         = r_ifPc;

  // Next-state and next-output logic. Every register holds by default;
  // each state only overrides what actually changes. Redirect is checked
  // first everywhere so it wins over responses, consumes and the predictor.
  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = r_pc;
    w_dropNext     = r_drop;
    w_ifValidNext  = r_ifValid;
    w_ifInstNext   = r_ifInst;
    w_ifPcNext     = r_ifPc;
`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
    w_misalignNext = r_misalign;
`else
    w_misalignNext = 1'b0;
`endif
    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pcNext = redirect_pc;
`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
        end else if (r_pc[1:0] != 2'b00) begin
          // Misaligned PC: skip memory and hand an exception slot to IF/ID.
          w_misalignNext = 1'b1;
          w_ifValidNext  = 1'b1;
          w_ifInstNext   = 32'd0;
          w_ifPcNext     = r_pc;
          w_stateNext    = S_OUT;
`endif
        end else if (imem_req_ready) begin
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_drop || redirect_valid) begin
            // Stale response: throw it away. pc already holds the earlier
            // redirect target unless a fresh redirect arrives now.
            w_dropNext  = 1'b0;
            w_stateNext = S_REQ;
            if (redirect_valid) begin
              w_pcNext = redirect_pc;
            end
          end else begin
            w_ifInstNext  = imem_rsp_data;
            w_ifPcNext    = r_pc;
            w_ifValidNext = 1'b1;
            w_stateNext   = S_OUT;
          end
        end else if (redirect_valid) begin
          // The request cannot be cancelled at memory, so remember to drop it.
          w_pcNext   = redirect_pc;
          w_dropNext = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || !ifid_stall) begin
          w_pcNext       = redirect_valid ? redirect_pc
                         : (bpu_jump ? bpu_target : r_pc + 64'd4);
          w_ifValidNext  = 1'b0;
          w_ifInstNext   = 32'd0;
          w_ifPcNext     = 64'd0;
          w_misalignNext = 1'b0;
          w_stateNext    = S_REQ;
        end
      end
      default: begin
        w_stateNext = S_REQ;
      end
    endcase
  end

  // State and output registers; reset returns to fetching RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_ifValid <= 1'b0;
      r_ifInst  <= 32'd0;
      r_ifPc    <= 64'd0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_drop    <= w_dropNext;
      r_ifValid <= w_ifValidNext;
      r_ifInst  <= w_ifInstNext;
      r_ifPc    <= w_ifPcNext;
    end
  end

`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
  // Misalign flag lives beside the output slot it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalignNext;
    end
  end
`else
  logic w_unusedMisalign;
  assign w_unusedMisalign = w_misalignNext;
`endif

endmodule

// File: tb/tb_ysyx_22051013_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22051013_if_fetch
//
// Scoreboard bench for the fetch stage. The stimulus process drives random
// control inputs and a variable-latency memory, tracks the architectural
// next-PC (redirect, predictor, PC+4) and pushes each instruction that must
// reach IF/ID into a queue. A separate monitor pops and compares whenever a
// new output slot appears, and checks hold/clear behaviour of the outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_22051013_if_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        ifid_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        bpu_jump;
  logic [63:0] bpu_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        fetch_misalign;

  ysyx_22051013_if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifid_stall     (ifid_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bpu_jump       (bpu_jump),
    .bpu_target     (bpu_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .fetch_misalign (fetch_misalign)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } item_t;

  item_t sbQ[$];
  int    nAssert = 0;
  int    nFail   = 0;
  bit    running = 0;
  int    idleCycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed hash of the word address.
  function automatic logic [31:0] memWord(input logic [63:0] addr);
    logic [31:0] a;
    a = addr[31:0] & 32'hFFFF_FFFC;
    return (a * 32'h9E37_79B1) ^ {addr[63:48], 16'h0013};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] randPc();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    if (sel == 1) return 64'h0000_0000_8000_0002;
    return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
  endfunction

  // Architectural model state and memory model state.
  logic [63:0] expPc;
  bit          outstanding;
  bit          stale;
  int          latCnt;
  logic [63:0] memAddr;

  // Drive one cycle of inputs at the negedge. directed=1 gives the plain
  // sequential pattern: memory always ready, 1-cycle latency, no stalls.
  task automatic applyStimulus(input bit directed);
    if (directed) begin
      imem_req_ready = 1'b1;
      ifid_stall     = 1'b0;
      redirect_valid = 1'b0;
      bpu_jump       = 1'b0;
    end else begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      ifid_stall     = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      bpu_jump       = ($urandom_range(0, 3) == 0);
    end
    redirect_pc = randPc();
    bpu_target  = randPc() & 64'hFFFF_FFFF_FFFF_FFFC;
    if (outstanding && latCnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memAddr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (outstanding) latCnt--;
    end
  endtask

  // Advance the reference model for the cycle whose inputs are now applied.
  task automatic modelCycle(input bit directed);
    item_t it;
    if (imem_req_valid && imem_req_ready) begin
      nAssert++;
      if (outstanding) begin
        nFail++;
        $display("[TB] FAIL second_request actual=1 required=0 at %0t", $time);
      end
      checkOutput("req_addr", imem_req_addr, {expPc[63:2], 2'b00});
      outstanding = 1;
      stale       = 0;
      latCnt      = directed ? 0 : $urandom_range(0, 2);
      memAddr     = imem_req_addr;
    end else if (imem_rsp_valid) begin
      if (!stale && !redirect_valid) begin
        it.pc   = expPc;
        it.inst = memWord({expPc[63:2], 2'b00});
        it.mis  = 1'b0;
        sbQ.push_back(it);
      end
      outstanding = 0;
    end else if (outstanding && redirect_valid) begin
      stale = 1;
    end
`ifdef YSYX_22051013_FETCH_ALIGN_CHK_EN
    if (!outstanding && !if_valid && !redirect_valid && expPc[1:0] != 2'b00) begin
      checkOutput("misalign_no_req", {63'd0, imem_req_valid}, 64'd0);
      it.pc   = expPc;
      it.inst = 32'd0;
      it.mis  = 1'b1;
      sbQ.push_back(it);
    end
`endif
    if (redirect_valid) expPc = redirect_pc;
    else if (if_valid && !ifid_stall) expPc = bpu_jump ? bpu_target : expPc + 64'd4;
  endtask

  // Monitor: compares each newly presented slot against the scoreboard and
  // checks that held slots stay stable and idle outputs stay zero.
  bit          prevValid = 0;
  bit          prevHeld  = 0;
  logic [63:0] heldPc;
  logic [31:0] heldInst;
  logic        heldMis;

  initial begin
    item_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (running) begin
        if (!if_valid) begin
          checkOutput("idle_zero", {if_inst, if_pc[31:0]} | {32'd0, if_pc[63:32]}, 64'd0);
          checkOutput("idle_misalign", {63'd0, fetch_misalign}, 64'd0);
          if (prevHeld) checkOutput("held_valid", 64'd0, 64'd1);
        end else if (prevHeld) begin
          checkOutput("held_pc", if_pc, heldPc);
          checkOutput("held_inst", {32'd0, if_inst}, {32'd0, heldInst});
          checkOutput("held_mis", {63'd0, fetch_misalign}, {63'd0, heldMis});
        end else if (prevValid) begin
          checkOutput("consumed_cleared", 64'd1, 64'd0);
        end else begin
          idleCycles = 0;
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_inst_pc", if_pc, 64'd0);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("out_pc", if_pc, exp.pc);
            checkOutput("out_inst", {32'd0, if_inst}, {32'd0, exp.inst});
            checkOutput("out_misalign", {63'd0, fetch_misalign}, {63'd0, exp.mis});
          end
        end
        prevValid = if_valid;
        prevHeld  = if_valid && ifid_stall && !redirect_valid;
        heldPc    = if_pc;
        heldInst  = if_inst;
        heldMis   = fetch_misalign;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    ifid_stall     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    bpu_jump       = 1'b0;
    bpu_target     = 64'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    outstanding    = 0;
    stale          = 0;
    latCnt         = 0;
    memAddr        = 64'd0;
    expPc          = RESET_PC;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_if_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("reset_if_pc", if_pc, 64'd0);
    checkOutput("reset_if_inst", {32'd0, if_inst}, 64'd0);
    checkOutput("reset_misalign", {63'd0, fetch_misalign}, 64'd0);
    checkOutput("reset_req_valid", {63'd0, imem_req_valid}, 64'd1);
    checkOutput("reset_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    rst     = 1'b0;
    running = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      applyStimulus(cyc < 30);
      #1;
      modelCycle(cyc < 30);
      idleCycles++;
      if (idleCycles > 200) begin
        checkOutput("progress_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(negedge clk);
    #3;
    running = 0;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
